// File: rtl/lib_cpu.sv
`default_nettype none
// ============================================================================
//  Package     : lib_cpu
//  Description : CPU-wide constants shared by the execute-stage resources.
//                MAX_XLEN is the widest operand any execute unit supports;
//                width-generic helper functions are written at this width
//                and callers zero-extend / truncate around them.
//  Revision    : 1.0  initial release
// ============================================================================
package lib_cpu;

    localparam int MAX_XLEN = 64;

endpackage
`default_nettype wire

// File: rtl/lib_muldiv.sv
`default_nettype none
// ============================================================================
//  Package     : lib_muldiv
//  Description : Types, state encoding and single-step arithmetic helpers for
//                the iterative multiply/divide unit (alu_muldiv).
//                fn_mul_step / fn_div_step work at MD_W bits; because both
//                are written so that zero-extended operands give the same
//                low-order result, any XLEN up to MD_W can use them.
//  Revision    : 1.0  initial release
// ============================================================================
package lib_muldiv;

    import lib_cpu::*;

    localparam int MD_W = MAX_XLEN;

    typedef enum logic [2:0] {
        OPT_MUL   = 3'd0,
        OPT_MULHU = 3'd1,
        OPT_DIVU  = 3'd2,
        OPT_REMU  = 3'd3,
        OPT_DIV   = 3'd4,
        OPT_REM   = 3'd5
    } muldiv_opt_e;

    // MULDIV_STATE encoding
    typedef logic [1:0] muldiv_state_t;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_FIX  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    // Request as issued by the execute stage (operands at maximum width).
    typedef struct packed {
        logic [2:0]      opt;
        logic [MD_W-1:0] a;
        logic [MD_W-1:0] b;
    } muldiv_req_t;

    // MSB-first shift-add: acc' = 2*acc + (mbit ? mcand : 0).
    // Consuming the multiplier from its MSB keeps the step independent of
    // the operand width, so the same function serves every XLEN.
    function automatic logic [2*MD_W-1:0] fn_mul_step(
        input logic [2*MD_W-1:0] acc,
        input logic [MD_W-1:0]   mcand,
        input logic              mbit
    );
        fn_mul_step = (acc << 1) + (mbit ? {{MD_W{1'b0}}, mcand} : '0);
    endfunction

    // Restoring divide step. Returns {new_remainder, quotient_bit}.
    // The quotient bit is 1 when the trial subtraction does not borrow.
    function automatic logic [MD_W:0] fn_div_step(
        input logic [MD_W-1:0] rem,
        input logic [MD_W-1:0] dvsr,
        input logic            nbit
    );
        logic [MD_W:0]   shifted;
        logic [MD_W+1:0] diff;
        logic            borrow;
        shifted = {rem, nbit};
        diff    = {1'b0, shifted} - {2'b00, dvsr};
        borrow  = diff[MD_W+1];
        fn_div_step = borrow ? {MD_W'(shifted), 1'b0} : {MD_W'(diff), 1'b1};
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_muldiv_step.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv_step
//  Description : Combinational single-step datapath of the iterative
//                multiply/divide unit. One call = one radix-2 iteration.
//  Revision    : 1.0  initial release
//
//  Ports
//    is_div_i : 1 = restoring divide step, 0 = shift-add multiply step
//    acc_i    : 2*XLEN accumulator. MUL: partial product.
//               DIV: {remainder, dividend/quotient shift register}
//    a_i      : multiplicand (unused by divide)
//    b_i      : MUL: multiplier, consumed from MSB; DIV: divisor
//    acc_o    : accumulator after the step
//    b_o      : b after the step (multiplier shifted left; divisor kept)
// ============================================================================
module alu_muldiv_step
    import lib_muldiv::*;
#(
    parameter int XLEN = 32
) (
    input  logic              is_div_i,
    input  logic [2*XLEN-1:0] acc_i,
    input  logic [XLEN-1:0]   a_i,
    input  logic [XLEN-1:0]   b_i,
    output logic [2*XLEN-1:0] acc_o,
    output logic [XLEN-1:0]   b_o
);

    localparam int PW  = 2 * XLEN;
    localparam int MW2 = 2 * MD_W;

    logic [MW2-1:0] w_mul_full;
    logic [MD_W:0]  w_div_full;
    logic [PW-1:0]  w_acc_mul;
    logic [PW-1:0]  w_acc_div;

    assign w_mul_full = fn_mul_step(MW2'(acc_i), MD_W'(a_i), b_i[XLEN-1]);
    assign w_acc_mul  = PW'(w_mul_full);

    // The next dividend bit leaves the top of the low half while the new
    // quotient bit enters at its bottom.
    assign w_div_full = fn_div_step(MD_W'(acc_i[PW-1:XLEN]), MD_W'(b_i), acc_i[XLEN-1]);
    assign w_acc_div  = {XLEN'(w_div_full >> 1), acc_i[XLEN-2:0], w_div_full[0]};

    assign acc_o = is_div_i ? w_acc_div : w_acc_mul;
    assign b_o   = is_div_i ? b_i : {b_i[XLEN-2:0], 1'b0};

endmodule
`default_nettype wire

// File: rtl/alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : alu_muldiv
//  Description : Iterative radix-2 multiply/divide execute resource.
//                IDLE -> CALC (XLEN steps) -> FIX (1 cycle) -> DONE.
//                Accept at edge t gives rsp_valid from edge t+XLEN+1.
//                Compile-time option ALU_MULDIV_SIGNED_EN enables the signed
//                DIV (4) / REM (5) opcodes; otherwise they return 0.
//  Revision    : 1.0  initial release
//
//  Ports
//    clk       : clock, rising edge
//    rst       : synchronous active-high reset
//    req_valid : request present          req_ready : unit idle, can accept
//    req_opt   : opcode                   req_a/b   : operands
//    rsp_valid : result held (DONE)       rsp_ready : consumer takes result
//    rsp_data  : result                   busy      : operation in flight
// ============================================================================
module alu_muldiv
    import lib_muldiv::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      req_opt,
    input  logic [XLEN-1:0] req_a,
    input  logic [XLEN-1:0] req_b,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_data,
    output logic            busy
);

    localparam int CNT_W = $clog2(XLEN + 1);
    localparam int PW    = 2 * XLEN;

    muldiv_state_t    state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       opt_q, opt_d;
    logic [XLEN-1:0]  a_q, a_d;
    logic [XLEN-1:0]  b_q, b_d;
    logic [PW-1:0]    acc_q, acc_d;
    logic [XLEN-1:0]  rsp_q, rsp_d;

    logic [XLEN-1:0]  w_a_in;
    logic [XLEN-1:0]  w_b_in;
    logic             w_req_div;
    logic             w_is_div;
    logic [PW-1:0]    w_acc_step;
    logic [XLEN-1:0]  w_b_step;
    logic [XLEN-1:0]  w_lo;
    logic [XLEN-1:0]  w_hi;
    logic             w_bzero;
    logic [XLEN-1:0]  w_result;

    // Every code from 2 upward runs the divide datapath; illegal codes are
    // zeroed in FIX, so which datapath they exercise does not matter.
    assign w_req_div = req_opt[1] | req_opt[2];
    assign w_is_div  = opt_q[1] | opt_q[2];

`ifdef ALU_MULDIV_SIGNED_EN
    logic neg_quo_q, neg_quo_d;
    logic neg_rem_q, neg_rem_d;
    logic w_neg_quo_in;
    logic w_neg_rem_in;
    logic w_req_signed;

    // Signed ops run on magnitudes; the sign of each result is recorded on
    // accept and restored in FIX. |MIN| wraps to MIN, which read as unsigned
    // is exactly 2^(XLEN-1), so the MIN / -1 overflow falls out naturally.
    assign w_req_signed = (req_opt == OPT_DIV) || (req_opt == OPT_REM);
    assign w_a_in       = (w_req_signed && req_a[XLEN-1]) ? -req_a : req_a;
    assign w_b_in       = (w_req_signed && req_b[XLEN-1]) ? -req_b : req_b;
    assign w_neg_quo_in = w_req_signed && (req_a[XLEN-1] ^ req_b[XLEN-1]);
    assign w_neg_rem_in = w_req_signed && req_a[XLEN-1];
`else
    assign w_a_in = req_a;
    assign w_b_in = req_b;
`endif

    alu_muldiv_step #(
        .XLEN (XLEN)
    ) u_step (
        .is_div_i (w_is_div),
        .acc_i    (acc_q),
        .a_i      (a_q),
        .b_i      (b_q),
        .acc_o    (w_acc_step),
        .b_o      (w_b_step)
    );

    // FIX-stage result selection and special cases
    always_comb begin
        w_lo     = acc_q[XLEN-1:0];
        w_hi     = acc_q[PW-1:XLEN];
        w_bzero  = (b_q == '0);
        w_result = '0;
        case (opt_q)
            OPT_MUL:   w_result = w_lo;
            OPT_MULHU: w_result = w_hi;
            OPT_DIVU:  w_result = w_bzero ? '1 : w_lo;
            // Divide by zero leaves the dividend in the remainder half.
            OPT_REMU:  w_result = w_hi;
`ifdef ALU_MULDIV_SIGNED_EN
            OPT_DIV:   w_result = w_bzero ? '1 : (neg_quo_q ? -w_lo : w_lo);
            OPT_REM:   w_result = neg_rem_q ? -w_hi : w_hi;
`endif
            default:   w_result = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        opt_d   = opt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        rsp_d   = rsp_q;
`ifdef ALU_MULDIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d = ST_CALC;
                    cnt_d   = CNT_W'(XLEN);
                    opt_d   = req_opt;
                    a_d     = w_a_in;
                    b_d     = w_b_in;
                    acc_d   = w_req_div ? {{XLEN{1'b0}}, w_a_in} : '0;
`ifdef ALU_MULDIV_SIGNED_EN
                    neg_quo_d = w_neg_quo_in;
                    neg_rem_d = w_neg_rem_in;
`endif
                end
            end
            ST_CALC: begin
                acc_d = w_acc_step;
                b_d   = w_b_step;
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = ST_FIX;
                end
            end
            ST_FIX: begin
                rsp_d   = w_result;
                state_d = ST_DONE;
            end
            ST_DONE: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            opt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            rsp_q   <= '0;
`ifdef ALU_MULDIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            opt_q   <= opt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            rsp_q   <= rsp_d;
`ifdef ALU_MULDIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    assign req_ready = (state_q == ST_IDLE);
    assign rsp_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign rsp_data  = rsp_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_muldiv.sv
`default_nettype none
// ============================================================================
//  Module      : tb_alu_muldiv
//  Description : Self-checking bench for alu_muldiv (XLEN=32). Expected
//                results come from a plain-arithmetic reference model;
//                handshake timing is checked against the fixed latency.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_alu_muldiv;

    localparam int XLEN = 32;
    localparam int LAT  = XLEN + 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [2:0]  req_opt;
    logic [31:0] req_a;
    logic [31:0] req_b;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    alu_muldiv #(
        .XLEN (XLEN)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_opt   (req_opt),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .busy      (busy)
    );

    // Reference model: the arithmetic meaning of each opcode.
    function automatic logic [31:0] model(input logic [2:0] opt, input logic [31:0] a,
                                          input logic [31:0] b);
        logic [63:0] prod;
        logic [31:0] res;
        prod = {32'd0, a} * {32'd0, b};
        res  = '0;
        case (opt)
            3'd0: res = prod[31:0];
            3'd1: res = prod[63:32];
            3'd2: res = (b == 32'd0) ? 32'hFFFF_FFFF : a / b;
            3'd3: res = (b == 32'd0) ? a : a % b;
`ifdef ALU_MULDIV_SIGNED_EN
            3'd4: begin
                if (b == 32'd0) res = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'h8000_0000;
                else res = 32'($signed(a) / $signed(b));
            end
            3'd5: begin
                if (b == 32'd0) res = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
                else res = 32'($signed(a) % $signed(b));
            end
`endif
            default: res = '0;
        endcase
        return res;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Waits (bounded) for req_ready, presents one request, returns 1ns after
    // the accepting edge with req_valid dropped.
    task automatic send(input logic [2:0] opt, input logic [31:0] a, input logic [31:0] b);
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        check("send_ready", 32'(req_ready), 32'd1);
        req_valid = 1'b1;
        req_opt   = opt;
        req_a     = a;
        req_b     = b;
        tick();
        req_valid = 1'b0;
        req_opt   = 3'($urandom_range(0, 7));
        req_a     = $urandom;
        req_b     = $urandom;
    endtask

    // Called right after the accepting edge: checks latency, stability while
    // the consumer stalls for 'hold' cycles, and the response handshake.
    task automatic collect(input string tag, input logic [31:0] exp, input int hold);
        int lat;
        lat = 0;
        while (!rsp_valid && lat < 100) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'(LAT));
        for (int i = 0; i < hold; i++) begin
            check({tag, "_stall_data"}, rsp_data, exp);
            check({tag, "_stall_ready"}, 32'(req_ready), 32'd0);
            tick();
        end
        check({tag, "_data"}, rsp_data, exp);
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check({tag, "_post_valid"}, 32'(rsp_valid), 32'd0);
        check({tag, "_post_ready"}, 32'(req_ready), 32'd1);
    endtask

    task automatic op(input string tag, input logic [2:0] opt, input logic [31:0] a,
                      input logic [31:0] b, input int hold);
        send(opt, a, b);
        collect(tag, model(opt, a, b), hold);
    endtask

    initial begin
        logic [2:0]  r_opt;
        logic [31:0] r_a;
        logic [31:0] r_b;
        logic [31:0] exp_hold;
        int          n;
        bit          seen;

        rst       = 1'b1;
        req_valid = 1'b0;
        req_opt   = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (3) tick();
        check("rst_req_ready", 32'(req_ready), 32'd1);
        check("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        check("rst_rsp_data", rsp_data, 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        tick();

        // Directed cases
        op("mul_7x6", 3'd0, 32'd7, 32'd6, 0);
        op("mul_ff", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        op("mulhu_ff", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
        op("divu_100_7", 3'd2, 32'd100, 32'd7, 0);
        op("remu_100_7", 3'd3, 32'd100, 32'd7, 0);
        op("divu_by0", 3'd2, 32'd9, 32'd0, 0);
        op("remu_by0", 3'd3, 32'd5, 32'd0, 0);
        op("div_m7_2", 3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        op("rem_m7_2", 3'd5, 32'hFFFF_FFF9, 32'd2, 0);
        op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        op("rem_ovf", 3'd5, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        op("div_by0", 3'd4, 32'hFFFF_FFF9, 32'd0, 0);
        op("rem_by0", 3'd5, 32'hFFFF_FFF9, 32'd0, 0);
        op("opt6", 3'd6, 32'd12, 32'd3, 0);
        op("opt7", 3'd7, 32'd12, 32'd3, 0);

        // Stall in DONE with a new request already waiting
        exp_hold = model(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        send(3'd1, 32'h1234_5678, 32'h9ABC_DEF0);
        n = 0;
        while (!rsp_valid && n < 100) begin
            tick();
            n++;
        end
        check("hold_lat", 32'(n), 32'(LAT));
        req_valid = 1'b1;
        req_opt   = 3'd2;
        req_a     = 32'd100;
        req_b     = 32'd7;
        for (int i = 0; i < 5; i++) begin
            check("hold_data", rsp_data, exp_hold);
            check("hold_req_ready", 32'(req_ready), 32'd0);
            check("hold_valid", 32'(rsp_valid), 32'd1);
            tick();
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        check("hold_turn_ready", 32'(req_ready), 32'd1);
        check("hold_turn_valid", 32'(rsp_valid), 32'd0);
        tick();
        req_valid = 1'b0;
        check("hold_accept_busy", 32'(busy), 32'd1);
        collect("hold_next", 32'd14, 0);

        // Randomized operations against the model
        for (int k = 0; k < 30; k++) begin
            r_opt = 3'($urandom_range(0, 7));
            r_a   = $urandom;
            case ($urandom_range(0, 3))
                0:       r_b = 32'd0;
                1:       r_b = 32'($urandom_range(1, 15));
                2:       r_b = 32'hFFFF_FFFF;
                default: r_b = $urandom;
            endcase
            if ($urandom_range(0, 7) == 0) r_a = 32'h8000_0000;
            op("rand", r_opt, r_a, r_b, int'($urandom_range(0, 2)));
        end

        // Reset in the middle of CALC discards the operation
        send(3'd0, 32'd123, 32'd456);
        repeat (9) tick();
        check("mid_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_ready", 32'(req_ready), 32'd1);
        check("mid_rst_valid", 32'(rsp_valid), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        seen = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (rsp_valid) seen = 1'b1;
            tick();
        end
        check("mid_rst_no_rsp", 32'(seen), 32'd0);
        op("after_rst", 3'd0, 32'd7, 32'd6, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/alu_muldiv.md
Name: alu_muldiv

Overview:
- Iterative radix-2 multiply/divide unit, parametrised in operand width.
- Sits beside the single-cycle execute functions as a multi-cycle execute resource.
- Execute stage issues a request over a valid/ready handshake. The unit computes in XLEN steps plus one fix-up cycle, then holds the result under a valid/ready response handshake.

Parameters:
XLEN, 32, operand/result width in bits; legal range 4..64
CNT_W, $clog2(XLEN+1), step counter width; derived, not overridden

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous, active-high reset
req_valid  input  1  request present
req_ready  output  1  unit can accept (state IDLE)
req_opt  input  3  operation code (see Behaviour)
req_a  input  XLEN  operand A (multiplicand / dividend)
req_b  input  XLEN  operand B (multiplier / divisor)
rsp_valid  output  1  result available (state DONE)
rsp_ready  input  1  consumer takes result
rsp_data  output  XLEN  result
busy  output  1  state != IDLE

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset values:
  - state=IDLE, counter=0.
  - req_ready=1, rsp_valid=0, rsp_data=0, busy=0.
- Opcodes:
  - 0 MUL: low XLEN bits of a*b.
  - 1 MULHU: high XLEN bits of unsigned a*b.
  - 2 DIVU.
  - 3 REMU.
  - 4 DIV, 5 REM: signed; only with the macro.
  - 6, 7 and disabled codes: illegal; result 0 with normal latency.
- State machine IDLE -> CALC -> FIX -> DONE -> IDLE:
  - IDLE: req_ready=1. On req_valid: latch opt/operands, counter=XLEN, go CALC.
  - CALC: one shift-add or restoring-subtract step per cycle, counter decrements. After the step with counter==1, go FIX.
  - FIX: apply sign correction and special cases, write rsp_data, go DONE. FIX always exists so latency is constant.
  - DONE: rsp_valid=1; rsp_data stable until rsp_valid&&rsp_ready at an edge, then IDLE.
- Latency: request accepted at edge t; rsp_valid=1 from edge t+XLEN+1.
- Throughput: next accept is no earlier than the edge after the response handshake; no same-edge turnaround.
- Datapath:
  - Multiply: 2*XLEN product register.
  - Divide: XLEN remainder register plus quotient register; shift left, trial subtract of b, quotient bit = no-borrow.
  - All arithmetic mod 2^XLEN except the product register.
- Divide by zero:
  - DIVU/DIV result all-ones.
  - REMU/REM result = a.
  - Normal latency is kept.
- Signed overflow: DIV with a=MIN, b=-1 gives MIN; REM gives 0.
- req_valid while not IDLE is ignored; the requester must hold it until req_ready.
- Reset mid-operation returns to IDLE and discards the operation; no response is produced.

Optional Feature:
- ALU_MULDIV_SIGNED_EN defined:
  - opt 4/5 enabled.
  - Operands are converted to magnitudes on accept.
  - FIX negates the quotient when sign(a)!=sign(b), and negates the remainder when a<0.
- Not defined:
  - opt 4/5 are illegal (result 0).
  - Sign-conversion logic is absent.

Decomposition:
- New package lib_muldiv, importing lib_cpu:
  - MULDIV_OPT enum for opcodes 0..5.
  - MULDIV_STATE enum (IDLE, CALC, FIX, DONE).
  - Request struct {opt, a, b}.
  - Pure functions fn_mul_step and fn_div_step.
- One sub-module is natural: muldiv_step, the combinational single-step datapath. It keeps the FSM module small and can be unit-tested alone.

Test Plan:
- XLEN=32, MUL 7*6 accepted at edge t -> rsp_valid rises at t+33, rsp_data=42; rsp_ready=1 -> req_ready=1 next cycle.
- MUL and MULHU with 0xFFFFFFFF*0xFFFFFFFF -> 0x00000001 and 0xFFFFFFFE.
- DIVU 100/7 -> 14, REMU 100/7 -> 2; DIVU 9/0 -> 0xFFFFFFFF, REMU 5/0 -> 5.
- Hold rsp_ready=0 for 5 cycles in DONE while driving a new req_valid -> rsp_data stable, req_ready=0, new request accepted only after the handshake.
- With ALU_MULDIV_SIGNED_EN: DIV -7/2 -> 0xFFFFFFFD, REM -> 0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> 0x80000000, REM -> 0. Without the macro: opt 4 -> 0.
- Assert rst at t+10 during CALC -> next cycle req_ready=1, rsp_valid=0, busy=0; no response emitted afterwards.
